// File: rtl/rshift_pkg.sv
// Shared helpers for the round-robin right-shift arbiter: parameter
// derivation and the rotating "first set bit from pointer" search.
package rshift_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDXW    = 3;

    function automatic int sel_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First index at or after ptr (wrapping modulo n) whose valid bit is set;
    // -1 when nothing is requesting.
    function automatic int rr_first(input logic [MAX_REQ-1:0] valid,
                                    input int unsigned         ptr,
                                    input int unsigned         n);
        int          result;
        int unsigned idx;
        logic [IDXW-1:0] idx_s;
        result = -1;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx   = (ptr + k) % n;
            idx_s = idx[IDXW-1:0];
            if (k < n && result < 0 && valid[idx_s]) begin
                result = int'(idx);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/logical_rshifter.sv
// Combinational logical right shifter, zero-filled from the MSB.
// Shift amounts at or beyond WIDTH yield zero.
module logical_rshifter #(
    parameter int WIDTH = 32,
    parameter int SELW  = 5
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [SELW-1:0]  shamt,
    output logic [WIDTH-1:0] result
);

    assign result = operand >> shamt;

endmodule

// File: rtl/rshift_arbiter.sv
// Round-robin arbiter sharing one logical right shifter between NREQ
// requesters, with a single registered response slot tagged by requester ID.
// Optional feature macro: RSHIFT_ARB_STICKY_EN (registers the OR of the
// shifted-out bits on rsp_sticky; otherwise rsp_sticky is tied low).
module rshift_arbiter
    import rshift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 2,
    localparam int SELW  = sel_width(WIDTH),
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SELW-1:0] req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_sticky
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;

    logic             free;
    logic             found;
    logic             accept;
    int               grant;
    logic [IDW-1:0]   g;
    logic [WIDTH-1:0] op;
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] shifted;

    // Grant search from the pointer, ready generation and operand mux.
    always_comb begin
        free   = !rsp_valid_q || rsp_ready;
        grant  = rr_first(MAX_REQ'(req_valid), 32'(ptr_q), NREQ);
        found  = (grant >= 0);
        g      = IDW'(grant);
        accept = found && free;
        req_ready = '0;
        op        = '0;
        sel       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (found && g == IDW'(i)) begin
                req_ready[i] = free;
                op           = req_data[i*WIDTH +: WIDTH];
                sel          = req_sel[i*SELW +: SELW];
            end
        end
    end

    logical_rshifter #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_shifter (
        .operand (op),
        .shamt   (sel),
        .result  (shifted)
    );

    // Response slot and pointer next state: load on accept, drain otherwise.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shifted;
            rsp_id_d    = g;
            ptr_d       = (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset takes priority over accept and drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef RSHIFT_ARB_STICKY_EN
    logic             rsp_sticky_q, rsp_sticky_d;
    logic [WIDTH-1:0] low_mask;

    // Sticky bit: OR of the operand bits that fall off the bottom.
    always_comb begin
        low_mask     = ~({WIDTH{1'b1}} << sel);
        rsp_sticky_d = rsp_sticky_q;
        if (accept) begin
            rsp_sticky_d = |(op & low_mask);
        end
    end

    // Sticky register follows the same load/hold rules as rsp_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sticky_q <= 1'b0;
        end else begin
            rsp_sticky_q <= rsp_sticky_d;
        end
    end

    assign rsp_sticky = rsp_sticky_q;
`else
    assign rsp_sticky = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
